// File: rtl/mmio_console_responder_pkg.sv
// Shared constants and types for the MMIO console responder: register offsets,
// default window base and the UART transmitter state encoding.
package mmio_console_responder_pkg;

    localparam logic [63:0] MMIO_BASE_DEFAULT = 64'h0000_0000_1000_0000;

    // Register offsets, selected by addr[4:3]
    localparam logic [1:0] MMIO_TOHOST  = 2'd0;
    localparam logic [1:0] MMIO_CONSOLE = 2'd1;
    localparam logic [1:0] MMIO_STATUS  = 2'd2;
    localparam logic [1:0] MMIO_MCYCLE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    // Expand 8 byte-lane enables into a 64-bit bit mask
    function automatic logic [63:0] lane_mask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mmio_console_responder_if.sv
// Processor data-memory port as seen by the MMIO responder; the processor side
// drives address/store signals, the responder returns load data and its select.
interface mmio_console_responder_if;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  byte_en;
    logic        wen;
    logic [63:0] rdata;
    logic        mmio_sel;

    modport master (
        output addr, wdata, byte_en, wen,
        input  rdata, mmio_sel
    );

    modport slave (
        input  addr, wdata, byte_en, wen,
        output rdata, mmio_sel
    );
endinterface

// File: rtl/mmio_console_responder_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output. Count carries one extra
// bit so that full and empty are distinguishable with power-of-two depth.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Full is judged on the pre-edge count, so a push to a full FIFO is lost
    // even when a pop happens on the same edge.
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_console_responder.sv
// MMIO responder beside dmem: TOHOST test-exit register, free-running MCYCLE,
// STATUS, and a FIFO-buffered 8N1 UART console transmitter.
module mmio_console_responder
    import mmio_console_responder_pkg::*;
#(
    parameter logic [63:0] MMIO_BASE    = MMIO_BASE_DEFAULT,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    mmio_console_responder_if.slave        bus,
    output logic                           tohost_valid,
    output logic [63:0]                    tohost_value,
    output logic                           uart_tx
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic        w_sel;
    logic [1:0]  w_off;
    logic        w_wr;
    logic [63:0] w_wmasked;
    logic        w_push;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [8:0]  w_count_ext;
    logic [7:0]  w_count8;
    logic [7:0]  w_fifo_dout;
    logic        w_tx_busy;
    logic [63:0] w_rdata;

    logic [63:0] r_tohost_value;
    logic        r_tohost_valid;
    logic [63:0] r_mcycle;
    logic [15:0] r_drop_count;

    uart_state_e r_state,    w_state_next;
    logic [15:0] r_baud_cnt, w_baud_next;
    logic [2:0]  r_bit_idx,  w_bit_next;
    logic [7:0]  r_shift,    w_shift_next;
    logic        r_uart_tx,  w_tx_next;
    logic        w_baud_done;

    assign w_sel     = (bus.addr[63:5] == MMIO_BASE[63:5]);
    assign w_off     = bus.addr[4:3];
    assign w_wr      = bus.wen && w_sel;
    assign w_wmasked = bus.wdata & lane_mask(bus.byte_en);
    assign w_push    = w_wr && (w_off == MMIO_CONSOLE) && bus.byte_en[0];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.wdata[7:0]),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count),
        .dout  (w_fifo_dout)
    );

    // A 256-deep FIFO can hold 256 entries, which the 8-bit STATUS field clamps
    assign w_count_ext = 9'(w_fifo_count);
    assign w_count8    = w_count_ext[8] ? 8'hFF : w_count_ext[7:0];
    assign w_tx_busy   = (r_state != IDLE);

    always_comb begin
        w_rdata = '0;
        if (w_sel) begin
            case (w_off)
                MMIO_TOHOST: w_rdata = r_tohost_value;
                MMIO_STATUS: w_rdata = {32'd0, r_drop_count, w_count8, 5'd0,
                                        w_tx_busy, w_fifo_empty, w_fifo_full};
                MMIO_MCYCLE: w_rdata = r_mcycle;
                default:     w_rdata = '0;
            endcase
        end
    end

    assign bus.rdata    = w_rdata;
    assign bus.mmio_sel = w_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tohost_value <= '0;
            r_tohost_valid <= 1'b0;
            r_mcycle       <= '0;
            r_drop_count   <= '0;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
            // First nonzero write freezes TOHOST so the exit code cannot be overwritten
            if (w_wr && (w_off == MMIO_TOHOST) && !r_tohost_valid) begin
                r_tohost_value <= w_wmasked;
                if (|w_wmasked) begin
                    r_tohost_valid <= 1'b1;
                end
            end
            if (w_push && w_fifo_full && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign tohost_valid = r_tohost_valid;
    assign tohost_value = r_tohost_value;

    assign w_baud_done = (r_baud_cnt == BAUD_LAST);

    // The line level is registered from the current state, so every symbol
    // appears one cycle after the state that produces it.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_tx_next    = 1'b1;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_baud_next  = '0;
                    w_state_next = START;
                end
            end
            START: begin
                w_tx_next = 1'b0;
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = DATA;
                end else begin
                    w_baud_next = r_baud_cnt + 16'd1;
                end
            end
            DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_state_next = IDLE;
                end else begin
                    w_baud_next = r_baud_cnt + 16'd1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_uart_tx  <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_idx  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_uart_tx  <= w_tx_next;
        end
    end

    assign uart_tx = r_uart_tx;

endmodule
